// File: rtl/miter_sequencer.sv
// Equivalence-check sequencer: drives LFSR stimulus to two DUT copies and
// compares their outputs LAT cycles later, reporting mismatch statistics.
module miter_sequencer #(
    parameter int OUT_W = 91,
    parameter int LAT   = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] num_vec,
    input  logic [44:0]      seed,
    output logic [15:0]      stim_wire0,
    output logic [9:0]       stim_wire1,
    output logic [5:0]       stim_wire2,
    output logic [12:0]      stim_wire3,
    input  logic [OUT_W-1:0] y_1,
    input  logic [OUT_W-1:0] y_2,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] mismatch_cnt,
    output logic [CNT_W-1:0] first_fail_idx,
    output logic             first_fail_vld
);

    typedef enum logic [2:0] {IDLE, SEED, DRIVE, DRAIN, DONE} state_t;

    localparam int DRAIN_CYC = (LAT == 0) ? 1 : LAT;

    state_t           state_q, state_d;
    logic [44:0]      lfsr_q, lfsr_d;
    logic [44:0]      seed_q, seed_d;
    logic [44:0]      stim_q, stim_d;
    logic [CNT_W-1:0] num_vec_q, num_vec_d;
    logic [CNT_W-1:0] vec_idx_q, vec_idx_d;
    logic [CNT_W-1:0] mismatch_cnt_q, mismatch_cnt_d;
    logic [CNT_W-1:0] first_fail_idx_q, first_fail_idx_d;
    logic             first_fail_vld_q, first_fail_vld_d;
    logic             pass_q, pass_d;
    logic [2:0]       drain_cnt_q, drain_cnt_d;

    logic             abort_act;
    logic             drv_vld;
    logic             cmp_vld;
    logic [CNT_W-1:0] cmp_idx;
    logic [44:0]      seed_fix;

    function automatic logic [44:0] lfsr_step(input logic [44:0] s);
        return {s[43:0], s[44] ^ s[43] ^ s[41] ^ s[40]};
    endfunction

    assign abort_act = abort && (state_q inside {SEED, DRIVE, DRAIN});
    assign drv_vld   = (state_q == DRIVE) && !abort_act;
    assign seed_fix  = (seed_q == '0) ? 45'h1 : seed_q;

    // Vector presented in cycle c is compared at the end of cycle c+LAT.
    generate
        if (LAT == 0) begin : g_nolat
            assign cmp_vld = drv_vld;
            assign cmp_idx = vec_idx_q;
        end else begin : g_lat
            logic [LAT-1:0]            vld_pipe_q, vld_pipe_d;
            logic [LAT-1:0][CNT_W-1:0] idx_pipe_q, idx_pipe_d;

            always_comb begin
                vld_pipe_d = '0;
                idx_pipe_d = idx_pipe_q;
                if (!abort_act) begin
                    vld_pipe_d[0] = drv_vld;
                    idx_pipe_d[0] = vec_idx_q;
                    for (int k = 1; k < LAT; k++) begin
                        vld_pipe_d[k] = vld_pipe_q[k-1];
                        idx_pipe_d[k] = idx_pipe_q[k-1];
                    end
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld_pipe_q <= '0;
                    idx_pipe_q <= '0;
                end else begin
                    vld_pipe_q <= vld_pipe_d;
                    idx_pipe_q <= idx_pipe_d;
                end
            end

            assign cmp_vld = vld_pipe_q[LAT-1];
            assign cmp_idx = idx_pipe_q[LAT-1];
        end
    endgenerate

    always_comb begin
        state_d          = state_q;
        lfsr_d           = lfsr_q;
        seed_d           = seed_q;
        stim_d           = stim_q;
        num_vec_d        = num_vec_q;
        vec_idx_d        = vec_idx_q;
        mismatch_cnt_d   = mismatch_cnt_q;
        first_fail_idx_d = first_fail_idx_q;
        first_fail_vld_d = first_fail_vld_q;
        pass_d           = pass_q;
        drain_cnt_d      = drain_cnt_q;

        if (cmp_vld && !abort_act && (y_1 != y_2)) begin
            if (mismatch_cnt_q != '1) mismatch_cnt_d = mismatch_cnt_q + CNT_W'(1);
            if (!first_fail_vld_q) begin
                first_fail_idx_d = cmp_idx;
                first_fail_vld_d = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = SEED;
                    seed_d    = seed;
                    num_vec_d = num_vec;
                end
            end
            SEED: begin
                vec_idx_d        = '0;
                mismatch_cnt_d   = '0;
                first_fail_idx_d = '0;
                first_fail_vld_d = 1'b0;
                pass_d           = 1'b0;
                drain_cnt_d      = '0;
                if (num_vec_q == '0) begin
                    state_d = DRAIN;
                end else begin
                    // Vector 0 is registered on entry so it is visible in the first DRIVE cycle;
                    // the LFSR then holds the state for the following vector.
                    state_d = DRIVE;
                    stim_d  = seed_fix;
                    lfsr_d  = lfsr_step(seed_fix);
                end
            end
            DRIVE: begin
                vec_idx_d = vec_idx_q + CNT_W'(1);
                if (vec_idx_q == num_vec_q - CNT_W'(1)) begin
                    state_d = DRAIN;
                end else begin
                    stim_d = lfsr_q;
                    lfsr_d = lfsr_step(lfsr_q);
                end
            end
            DRAIN: begin
                if (drain_cnt_q == 3'(DRAIN_CYC - 1)) begin
                    state_d = DONE;
                    pass_d  = (mismatch_cnt_d == '0);
                end else begin
                    drain_cnt_d = drain_cnt_q + 3'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (abort_act) begin
            state_d = IDLE;
            stim_d  = stim_q;
            lfsr_d  = lfsr_q;
            pass_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            lfsr_q           <= 45'h1;
            seed_q           <= '0;
            stim_q           <= '0;
            num_vec_q        <= '0;
            vec_idx_q        <= '0;
            mismatch_cnt_q   <= '0;
            first_fail_idx_q <= '0;
            first_fail_vld_q <= 1'b0;
            pass_q           <= 1'b0;
            drain_cnt_q      <= '0;
        end else begin
            state_q          <= state_d;
            lfsr_q           <= lfsr_d;
            seed_q           <= seed_d;
            stim_q           <= stim_d;
            num_vec_q        <= num_vec_d;
            vec_idx_q        <= vec_idx_d;
            mismatch_cnt_q   <= mismatch_cnt_d;
            first_fail_idx_q <= first_fail_idx_d;
            first_fail_vld_q <= first_fail_vld_d;
            pass_q           <= pass_d;
            drain_cnt_q      <= drain_cnt_d;
        end
    end

    assign stim_wire0     = stim_q[15:0];
    assign stim_wire1     = stim_q[25:16];
    assign stim_wire2     = stim_q[31:26];
    assign stim_wire3     = stim_q[44:32];
    assign busy           = state_q inside {SEED, DRIVE, DRAIN};
    assign done           = (state_q == DONE);
    assign pass           = pass_q;
    assign mismatch_cnt   = mismatch_cnt_q;
    assign first_fail_idx = first_fail_idx_q;
    assign first_fail_vld = first_fail_vld_q;

endmodule
